// File: rtl/stopwatch_lap_controller_if.sv
// Button/counter/display bundle for the stopwatch lap controller.
// slave: controller side (pulses and time in, strobes and display out).
interface stopwatch_lap_controller_if #(
   parameter int TIME_W = 24,
   parameter int DEPTH  = 4
);
   localparam int IW = $clog2(DEPTH);

   logic              ss_pulse;
   logic              lap_pulse;
   logic              aux_pulse;
   logic [TIME_W-1:0] time_in;
   logic              count_en;
   logic              count_clr;
   logic [TIME_W-1:0] disp_time;
   logic [IW-1:0]     lap_idx;
   logic [IW:0]       lap_cnt;
   logic              lap_ovf;
   logic [2:0]        state;

   modport master (
      output ss_pulse, lap_pulse, aux_pulse, time_in,
      input  count_en, count_clr, disp_time,
      input  lap_idx, lap_cnt, lap_ovf, state
   );

   modport slave (
      input  ss_pulse, lap_pulse, aux_pulse, time_in,
      output count_en, count_clr, disp_time,
      output lap_idx, lap_cnt, lap_ovf, state
   );
endinterface

// File: rtl/stopwatch_lap_controller.sv
// Stopwatch sequencer: run/stop/lap/recall FSM, count prescaler, lap memory.
// Ports: mclk, reset (sync, high), bus (slave): pulses, time_in -> strobes, display.
module stopwatch_lap_controller #(
   parameter int TIME_W = 24,
   parameter int DIV    = 500000,
   parameter int DEPTH  = 4
) (
   input  logic mclk,
   input  logic reset,
   stopwatch_lap_controller_if.slave bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int PW = $clog2(DIV);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RUN    = 3'd1;
   localparam logic [2:0] STOP   = 3'd2;
   localparam logic [2:0] LAP    = 3'd3;
   localparam logic [2:0] RECALL = 3'd4;

   logic [2:0]        st_q, st_n;
   logic [PW-1:0]     pre_q, pre_n;
   logic [IW:0]       cnt_q, cnt_n;
   logic [IW-1:0]     ridx_q, ridx_n;
   logic              ovf_q, ovf_n;
   logic [TIME_W-1:0] frz_q, frz_n;
   logic [TIME_W-1:0] disp_q, disp_n;
   logic              en_q, en_n;
   logic              clr_q, clr_n;
   logic              wr;
   logic [IW-1:0]     last_idx;

   logic [TIME_W-1:0] mem [DEPTH];

   // Priority ss > lap > aux; losers are dropped.
   logic ss, lp, ax;
   assign ss = bus.ss_pulse;
   assign lp = bus.lap_pulse & ~ss;
   assign ax = bus.aux_pulse & ~ss & ~bus.lap_pulse;

   always_comb begin
      st_n   = st_q;
      cnt_n  = cnt_q;
      ovf_n  = ovf_q;
      ridx_n = ridx_q;
      frz_n  = frz_q;
      wr     = 1'b0;
      clr_n  = 1'b0;
      unique case (st_q)
         IDLE: begin
            if (ss) st_n = RUN;
         end
         RUN, LAP: begin
            if (ss) begin
               st_n = STOP;
            end else if (lp) begin
               st_n  = LAP;
               frz_n = bus.time_in;
               if (cnt_q < (IW+1)'(DEPTH)) begin
                  wr    = 1'b1;
                  cnt_n = cnt_q + (IW+1)'(1);
               end else begin
                  ovf_n = 1'b1;
               end
            end else if (ax && st_q == LAP) begin
               st_n = RUN;
            end
         end
         STOP: begin
            if (ss) begin
               st_n = RUN;
            end else if (lp) begin
               st_n  = IDLE;
               clr_n = 1'b1;
               cnt_n = '0;
               ovf_n = 1'b0;
            end else if (ax && cnt_q != '0) begin
               st_n   = RECALL;
               ridx_n = '0;
            end
         end
         RECALL: begin
            if (ss) begin
               st_n = STOP;
            end else if (ax) begin
               if ({1'b0, ridx_q} == cnt_q - (IW+1)'(1))
                  ridx_n = '0;
               else
                  ridx_n = ridx_q + IW'(1);
            end
         end
         default: st_n = IDLE;
      endcase
   end

   // Prescaler advances on every RUN/LAP edge, so count_en marks
   // the cycle in which it sits at DIV-1 and is about to wrap.
   always_comb begin
      pre_n = pre_q;
      if (st_n == IDLE)
         pre_n = '0;
      else if (st_q == RUN || st_q == LAP)
         pre_n = (pre_q == PW'(DIV-1)) ? '0 : pre_q + PW'(1);
   end

   assign en_n = (st_n == RUN || st_n == LAP)
              && (pre_n == PW'(DIV-1));

   // Display source follows the state being entered so disp_time
   // lines up with state and lap_idx.
   always_comb begin
      disp_n = bus.time_in;
      if (st_n == LAP)
         disp_n = frz_n;
      else if (st_n == RECALL)
         disp_n = mem[ridx_n];
   end

   always_ff @(posedge mclk) begin
      if (reset) begin
         st_q   <= IDLE;
         pre_q  <= '0;
         cnt_q  <= '0;
         ridx_q <= '0;
         ovf_q  <= 1'b0;
         frz_q  <= '0;
         disp_q <= '0;
         en_q   <= 1'b0;
         clr_q  <= 1'b0;
      end else begin
         st_q   <= st_n;
         pre_q  <= pre_n;
         cnt_q  <= cnt_n;
         ridx_q <= ridx_n;
         ovf_q  <= ovf_n;
         frz_q  <= frz_n;
         disp_q <= disp_n;
         en_q   <= en_n;
         clr_q  <= clr_n;
      end
   end

   always_ff @(posedge mclk) begin
      if (!reset && wr)
         mem[cnt_q[IW-1:0]] <= bus.time_in;
   end

   // cnt==DEPTH truncates to 0, so minus one lands on DEPTH-1.
   assign last_idx = (cnt_q == '0) ? '0 : cnt_q[IW-1:0] - IW'(1);

   assign bus.state     = st_q;
   assign bus.count_en  = en_q;
   assign bus.count_clr = clr_q;
   assign bus.disp_time = disp_q;
   assign bus.lap_cnt   = cnt_q;
   assign bus.lap_ovf   = ovf_q;
   assign bus.lap_idx   = (st_q == RECALL) ? ridx_q : last_idx;
endmodule

// File: tb/tb_stopwatch_lap_controller.sv
// Scoreboard bench for stopwatch_lap_controller (DIV=4, DEPTH=4).
// Driver queues expected field values per cycle; monitor compares at negedge.
module tb_stopwatch_lap_controller;
   localparam int TW = 24;

   localparam int K_ST  = 0;
   localparam int K_CNT = 1;
   localparam int K_IDX = 2;
   localparam int K_OVF = 3;
   localparam int K_DSP = 4;
   localparam int K_EN  = 5;
   localparam int K_CLR = 6;

   typedef struct {
      int    cyc;
      int    k;
      int    v;
      string nm;
   } exp_t;

   logic mclk;
   logic reset;
   int   cyc;
   int   total;
   int   passed;
   exp_t q[$];

   stopwatch_lap_controller_if #(.TIME_W(TW), .DEPTH(4)) bus ();

   stopwatch_lap_controller #(
      .TIME_W(TW), .DIV(4), .DEPTH(4)
   ) dut (
      .mclk (mclk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   initial cyc = 0;
   always @(posedge mclk) cyc <= cyc + 1;

   function automatic int act(input int k);
      case (k)
         K_ST:    return int'(bus.state);
         K_CNT:   return int'(bus.lap_cnt);
         K_IDX:   return int'(bus.lap_idx);
         K_OVF:   return int'(bus.lap_ovf);
         K_DSP:   return int'(bus.disp_time);
         K_EN:    return int'(bus.count_en);
         default: return int'(bus.count_clr);
      endcase
   endfunction

   // Monitor: pops every record due this cycle.
   always @(negedge mclk) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc <= cyc) begin
            total++;
            if (q[i].cyc < cyc) begin
               $display("FAIL %s: check missed (cycle %0d, now %0d)",
                        q[i].nm, q[i].cyc, cyc);
            end else if (act(q[i].k) == q[i].v) begin
               passed++;
            end else begin
               $display("FAIL %s: got 0x%0h, expected 0x%0h",
                        q[i].nm, act(q[i].k), q[i].v);
            end
            q.delete(i);
         end
      end
   end

   task automatic exp(input int k, input int v,
                      input string nm, input int d = 0);
      exp_t e;
      e.cyc = cyc + d;
      e.k   = k;
      e.v   = v;
      e.nm  = nm;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge mclk);
         #1;
      end
   endtask

   task automatic pulse(input bit s, input bit l, input bit a);
      bus.ss_pulse  = s;
      bus.lap_pulse = l;
      bus.aux_pulse = a;
      @(posedge mclk);
      #1;
      bus.ss_pulse  = 1'b0;
      bus.lap_pulse = 1'b0;
      bus.aux_pulse = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: stimulus did not complete");
      $fatal(1);
   end

   initial begin
      total  = 0;
      passed = 0;
      reset  = 1'b1;
      bus.ss_pulse  = 1'b0;
      bus.lap_pulse = 1'b0;
      bus.aux_pulse = 1'b0;
      bus.time_in   = 24'h000555;
      idle(3);
      exp(K_ST,  0, "rst_state");
      exp(K_CNT, 0, "rst_lap_cnt");
      exp(K_IDX, 0, "rst_lap_idx");
      exp(K_OVF, 0, "rst_ovf");
      exp(K_DSP, 0, "rst_disp");
      exp(K_EN,  0, "rst_en");
      exp(K_CLR, 0, "rst_clr");
      idle(1);
      reset = 1'b0;

      // IDLE ignores lap and aux
      pulse(0, 1, 1);
      exp(K_ST,  0, "idle_ignore_state");
      exp(K_CNT, 0, "idle_ignore_cnt");

      // ss -> RUN, count_en at t0+4, +8, +12
      bus.time_in = 24'h000100;
      pulse(1, 0, 0);
      exp(K_ST, 1, "run_state");
      exp(K_EN, 0, "en_t0p3", 2);
      exp(K_EN, 1, "en_t0p4", 3);
      exp(K_EN, 0, "en_t0p5", 4);
      exp(K_EN, 1, "en_t0p8", 7);
      exp(K_EN, 1, "en_t0p12", 11);
      idle(12);

      // lap freezes display, aux resumes live view
      bus.time_in = 24'h000123;
      pulse(0, 1, 0);
      exp(K_ST,  3, "lap_state");
      exp(K_CNT, 1, "lap_cnt1");
      exp(K_IDX, 0, "lap_idx1");
      exp(K_DSP, 24'h000123, "lap_disp");
      bus.time_in = 24'h000124;
      idle(2);
      exp(K_DSP, 24'h000123, "lap_disp_held");
      pulse(0, 0, 1);
      exp(K_ST,  1, "aux_resume_state");
      exp(K_DSP, 24'h000124, "aux_resume_disp");
      bus.time_in = 24'h000125;
      idle(1);
      exp(K_DSP, 24'h000125, "run_disp_live");

      // stop, then clear
      pulse(1, 0, 0);
      exp(K_ST, 2, "stop_state");
      pulse(0, 1, 0);
      exp(K_ST,  0, "clr_state");
      exp(K_CLR, 1, "clr_pulse");
      exp(K_EN,  0, "clr_no_en");
      exp(K_CNT, 0, "clr_lap_cnt");
      exp(K_CLR, 0, "clr_pulse_end", 1);
      idle(2);

      // three laps, then recall walk
      pulse(1, 0, 0);
      bus.time_in = 24'h000201;
      pulse(0, 1, 0);
      bus.time_in = 24'h000202;
      pulse(0, 1, 0);
      exp(K_DSP, 24'h000202, "lap2_disp");
      bus.time_in = 24'h000203;
      pulse(0, 1, 0);
      exp(K_CNT, 3, "lap3_cnt");
      exp(K_IDX, 2, "lap3_idx");
      bus.time_in = 24'h000210;
      pulse(1, 0, 0);
      exp(K_ST,  2, "stop3_state");
      exp(K_DSP, 24'h000210, "stop3_disp");
      pulse(0, 0, 1);
      exp(K_ST,  4, "recall_state");
      exp(K_IDX, 0, "recall_idx0");
      exp(K_DSP, 24'h000201, "recall_disp0");
      pulse(0, 0, 1);
      exp(K_IDX, 1, "recall_idx1");
      exp(K_DSP, 24'h000202, "recall_disp1");
      pulse(0, 0, 1);
      exp(K_IDX, 2, "recall_idx2");
      exp(K_DSP, 24'h000203, "recall_disp2");
      pulse(0, 0, 1);
      exp(K_IDX, 0, "recall_wrap_idx");
      exp(K_DSP, 24'h000201, "recall_wrap_disp");
      pulse(0, 1, 0);
      exp(K_ST,  4, "recall_lap_ignored");
      exp(K_CNT, 3, "recall_cnt_kept");

      // reset during RECALL
      bus.time_in = 24'h000777;
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      exp(K_ST,  0, "mrst_state");
      exp(K_CNT, 0, "mrst_cnt");
      exp(K_IDX, 0, "mrst_idx");
      exp(K_DSP, 0, "mrst_disp");
      exp(K_EN,  0, "mrst_en");
      idle(1);

      // five laps: overflow
      pulse(1, 0, 0);
      for (int i = 1; i <= 5; i++) begin
         bus.time_in = 24'h000300 + 24'(i);
         pulse(0, 1, 0);
         if (i == 4) begin
            exp(K_CNT, 4, "ovf_cnt4");
            exp(K_IDX, 3, "ovf_idx4");
            exp(K_OVF, 0, "ovf_not_yet");
         end
      end
      exp(K_ST,  3, "ovf_state");
      exp(K_CNT, 4, "ovf_cnt_sat");
      exp(K_OVF, 1, "ovf_flag");
      exp(K_IDX, 3, "ovf_idx_sat");
      exp(K_DSP, 24'h000305, "ovf_frozen");
      pulse(1, 0, 0);
      exp(K_OVF, 1, "ovf_sticky");
      for (int i = 0; i < 5; i++) begin
         pulse(0, 0, 1);
         exp(K_IDX, i % 4, "ovf_recall_idx");
         exp(K_DSP, 24'h000301 + 24'(i % 4), "ovf_recall_disp");
      end
      pulse(1, 0, 0);
      exp(K_IDX, 3, "stop_idx_last");
      pulse(0, 1, 0);
      exp(K_CLR, 1, "ovf_clr_pulse");
      exp(K_OVF, 0, "ovf_cleared");
      exp(K_CNT, 0, "ovf_cnt_cleared");
      idle(1);

      // ss + lap together in RUN: stop, no capture
      pulse(1, 0, 0);
      bus.time_in = 24'h000400;
      pulse(1, 1, 0);
      exp(K_ST,  2, "sslap_state");
      exp(K_CNT, 0, "sslap_no_capture");
      exp(K_DSP, 24'h000400, "sslap_disp");
      for (int d = 1; d <= 8; d++)
         exp(K_EN, 0, "stop_no_en", d);
      idle(8);
      pulse(0, 0, 1);
      exp(K_ST, 2, "recall_empty_ignored");

      idle(3);
      while (q.size() != 0) begin
         total++;
         $display("FAIL %s: check never reached", q[0].nm);
         void'(q.pop_front());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
